// File: rtl/kplic_pkg.sv
// KPLIC shared constants and helpers.
// Default source count, priority width and the "no interrupt" ID.
package kplic_pkg;

  localparam int KPLIC_N_SRC     = 8;
  localparam int KPLIC_PRIO_W    = 3;
  localparam int KPLIC_NO_INT_ID = 0;

  function automatic int kplic_id_w(input int n_src);
    return $clog2(n_src + 1);
  endfunction

endpackage

// File: rtl/kplic_prio_tree.sv
// KPLIC arbiter: highest nonzero priority among eligible sources.
// Ties resolve to the lowest source ID; no winner gives ID 0.
module kplic_prio_tree #(
  parameter int N_SRC  = 8,
  parameter int PRIO_W = 3,
  parameter int ID_W   = 4
) (
  input  logic [N_SRC-1:0]        eligible,
  input  logic [N_SRC*PRIO_W-1:0] prio,
  output logic [ID_W-1:0]         best_id,
  output logic [PRIO_W-1:0]       best_prio
);

  always_comb begin
    best_id   = '0;
    best_prio = '0;
    // strict compare keeps the earlier (lower) ID on a tie
    for (int i = 0; i < N_SRC; i++) begin
      if (eligible[i] &&
          (prio[i*PRIO_W +: PRIO_W] > best_prio)) begin
        best_prio = prio[i*PRIO_W +: PRIO_W];
        best_id   = ID_W'(i + 1);
      end
    end
  end

endmodule

// File: rtl/kplic_target.sv
// KPLIC target: pending/in-service state, claim and completion.
// Define KPLIC_ARB_PIPE_EN to register the arbitration result.
module kplic_target
  import kplic_pkg::*;
#(
  parameter  int N_SRC  = KPLIC_N_SRC,
  parameter  int PRIO_W = KPLIC_PRIO_W,
  localparam int ID_W   = kplic_id_w(N_SRC)
) (
  input  logic                    kplic_clk,
  input  logic                    kplic_rstn,
  input  logic [N_SRC-1:0]        valid_int_req,
  input  logic [N_SRC*PRIO_W-1:0] int_priority,
  input  logic [PRIO_W-1:0]       threshold,
  input  logic                    claim_req,
  output logic [ID_W-1:0]         claim_id,
  output logic                    claim_vld,
  input  logic                    complete_req,
  input  logic [ID_W-1:0]         complete_id,
  output logic [N_SRC-1:0]        int_completion,
  output logic                    ext_irq,
  output logic [N_SRC-1:0]        int_pending
);

  logic [N_SRC-1:0]  pending_q, pending_d;
  logic [N_SRC-1:0]  in_service_q, in_service_d;
  logic [N_SRC-1:0]  int_completion_q, int_completion_d;
  logic [ID_W-1:0]   claim_id_q, claim_id_d;
  logic              claim_vld_q, claim_vld_d;
  logic              ext_irq_q, ext_irq_d;

  logic [N_SRC-1:0]  eligible;
  logic [N_SRC-1:0]  claim_mask;
  logic [N_SRC-1:0]  cpl_mask;
  logic [ID_W-1:0]   arb_id, best_id;
  logic [PRIO_W-1:0] arb_prio, best_prio;

  assign eligible = pending_q & ~in_service_q;

  kplic_prio_tree #(
    .N_SRC  (N_SRC),
    .PRIO_W (PRIO_W),
    .ID_W   (ID_W)
  ) u_prio_tree (
    .eligible  (eligible),
    .prio      (int_priority),
    .best_id   (arb_id),
    .best_prio (arb_prio)
  );

`ifdef KPLIC_ARB_PIPE_EN
  logic [ID_W-1:0]   best_id_q, best_id_d;
  logic [PRIO_W-1:0] best_prio_q, best_prio_d;

  assign best_id_d   = arb_id;
  assign best_prio_d = arb_prio;

  always_ff @(posedge kplic_clk or negedge kplic_rstn) begin
    if (!kplic_rstn) begin
      best_id_q   <= '0;
      best_prio_q <= '0;
    end else begin
      best_id_q   <= best_id_d;
      best_prio_q <= best_prio_d;
    end
  end

  assign best_id   = best_id_q;
  assign best_prio = best_prio_q;
`else
  assign best_id   = arb_id;
  assign best_prio = arb_prio;
`endif

  always_comb begin
    claim_mask = '0;
    cpl_mask   = '0;
    // eligibility guard drops a stale registered winner
    if (claim_req && (best_id != ID_W'(KPLIC_NO_INT_ID))) begin
      for (int i = 0; i < N_SRC; i++) begin
        if ((best_id == ID_W'(i + 1)) && eligible[i]) begin
          claim_mask[i] = 1'b1;
        end
      end
    end
    if (complete_req) begin
      for (int i = 0; i < N_SRC; i++) begin
        if ((complete_id == ID_W'(i + 1)) && in_service_q[i]) begin
          cpl_mask[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    // claim clear beats a same-cycle set; claim set beats completion
    pending_d        = (pending_q | valid_int_req) & ~claim_mask;
    in_service_d     = (in_service_q & ~cpl_mask) | claim_mask;
    int_completion_d = cpl_mask;
    claim_vld_d      = claim_req;
    claim_id_d       = (|claim_mask) ? best_id : '0;
    ext_irq_d        = (best_prio > threshold);
  end

  always_ff @(posedge kplic_clk or negedge kplic_rstn) begin
    if (!kplic_rstn) begin
      pending_q        <= '0;
      in_service_q     <= '0;
      int_completion_q <= '0;
      claim_id_q       <= '0;
      claim_vld_q      <= 1'b0;
      ext_irq_q        <= 1'b0;
    end else begin
      pending_q        <= pending_d;
      in_service_q     <= in_service_d;
      int_completion_q <= int_completion_d;
      claim_id_q       <= claim_id_d;
      claim_vld_q      <= claim_vld_d;
      ext_irq_q        <= ext_irq_d;
    end
  end

  assign int_pending    = pending_q;
  assign int_completion = int_completion_q;
  assign claim_id       = claim_id_q;
  assign claim_vld      = claim_vld_q;
  assign ext_irq        = ext_irq_q;

endmodule

// File: tb/tb_kplic_target.sv
// Bench for kplic_target: directed scenarios then random traffic
// against a behavioural pending/in-service model.
module tb_kplic_target;

  localparam int N  = 8;
  localparam int PW = 3;
  localparam int IW = 4;

  logic            kplic_clk = 1'b0;
  logic            kplic_rstn = 1'b0;
  logic [N-1:0]    valid_int_req = '0;
  logic [N*PW-1:0] int_priority;
  logic [PW-1:0]   threshold;
  logic            claim_req = 1'b0;
  logic [IW-1:0]   claim_id;
  logic            claim_vld;
  logic            complete_req = 1'b0;
  logic [IW-1:0]   complete_id = '0;
  logic [N-1:0]    int_completion;
  logic            ext_irq;
  logic [N-1:0]    int_pending;

  int pr [N];
  int thr = 0;
  bit [N-1:0] m_pend = '0;
  bit [N-1:0] m_svc = '0;
  int n_chk = 0;
  int n_bad = 0;

  always #5 kplic_clk = ~kplic_clk;

  always_comb begin
    for (int i = 0; i < N; i++) int_priority[i*PW +: PW] = PW'(pr[i]);
  end
  assign threshold = PW'(thr);

  kplic_target u_dut (
    .kplic_clk      (kplic_clk),
    .kplic_rstn     (kplic_rstn),
    .valid_int_req  (valid_int_req),
    .int_priority   (int_priority),
    .threshold      (threshold),
    .claim_req      (claim_req),
    .claim_id       (claim_id),
    .claim_vld      (claim_vld),
    .complete_req   (complete_req),
    .complete_id    (complete_id),
    .int_completion (int_completion),
    .ext_irq        (ext_irq),
    .int_pending    (int_pending)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // max priority first, then the lowest ID holding it
  function automatic void best(output int id, output int p);
    bit [N-1:0] el;
    el = m_pend & ~m_svc;
    p  = 0;
    id = 0;
    for (int s = 0; s < N; s++) if (el[s] && pr[s] > p) p = pr[s];
    if (p > 0)
      for (int s = N - 1; s >= 0; s--) if (el[s] && pr[s] == p) id = s + 1;
  endfunction

  int last_id;

  task automatic cyc(input bit [N-1:0] req, input bit clm,
                     input bit cpl, input int cid);
    int bid, bp;
    bit [N-1:0] ecpl;
    bit eirq;
    valid_int_req = req;
    claim_req     = clm;
    complete_req  = cpl;
    complete_id   = IW'(cid);
    best(bid, bp);
    eirq = (bp > thr);
    ecpl = '0;
    if (cpl && cid >= 1 && cid <= N && m_svc[cid-1]) ecpl[cid-1] = 1'b1;
    m_svc  = m_svc & ~ecpl;
    m_pend = m_pend | req;
    if (clm && bid != 0) begin
      m_pend[bid-1] = 1'b0;
      m_svc[bid-1]  = 1'b1;
    end
    last_id = bid;
    @(posedge kplic_clk);
    #1;
    check("pending", 32'(int_pending), 32'(m_pend));
    check("ext_irq", 32'(ext_irq), 32'(eirq));
    check("claim_vld", 32'(claim_vld), 32'(clm));
    if (clm) check("claim_id", 32'(claim_id), 32'(bid));
    check("completion", 32'(int_completion), 32'(ecpl));
    @(negedge kplic_clk);
    valid_int_req = '0;
    claim_req     = 1'b0;
    complete_req  = 1'b0;
    complete_id   = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {int_pending, int_completion, claim_id, claim_vld, ext_irq}, '0);
  endtask

  initial begin
    for (int i = 0; i < N; i++) pr[i] = 0;
    repeat (2) @(negedge kplic_clk);
    check_all_zero("reset_outs");
    kplic_rstn = 1'b1;
    @(negedge kplic_clk);

    // one-cycle request, prio 5 over threshold 2
    pr[2] = 5; thr = 2;
    cyc(8'h04, 0, 0, 0);
    check("r035_pend", 32'(int_pending[2]), 1);
    check("r035_irq0", 32'(ext_irq), 0);
    cyc('0, 0, 0, 0);
    check("r035_irq1", 32'(ext_irq), 1);
    cyc('0, 1, 0, 0);
    check("r035_claim", 32'(claim_id), 3);
    cyc('0, 0, 1, 3);
    check("r035_cpl", 32'(int_completion), 32'h04);

    // equal priorities: lower ID first
    thr = 0; pr[1] = 4; pr[4] = 4;
    cyc(8'h12, 0, 0, 0);
    cyc('0, 1, 0, 0);
    check("r036_id2", 32'(claim_id), 2);
    cyc('0, 1, 0, 0);
    check("r036_id5", 32'(claim_id), 5);
    cyc('0, 0, 1, 2);
    check("r036_irq_drop", 32'(ext_irq), 0);
    cyc('0, 0, 1, 5);

    // prio equal to threshold: no irq, but claimable
    pr[0] = 3; thr = 3;
    cyc(8'h01, 0, 0, 0);
    cyc('0, 0, 0, 0);
    check("r037_irq", 32'(ext_irq), 0);
    cyc('0, 1, 0, 0);
    check("r037_id", 32'(claim_id), 1);
    cyc('0, 0, 1, 1);

    // empty claim
    thr = 0;
    cyc('0, 1, 0, 0);
    check("r038_id", 32'(claim_id), 0);
    check("r038_vld", 32'(claim_vld), 1);
    cyc('0, 0, 0, 0);

    // completion decode
    pr[3] = 6;
    cyc(8'h08, 0, 0, 0);
    cyc('0, 1, 0, 0);
    check("r039_id", 32'(claim_id), 4);
    cyc('0, 0, 1, 4);
    check("r039_pulse", 32'(int_completion), 32'h08);
    cyc('0, 0, 0, 0);
    check("r039_single", 32'(int_completion), 0);
    cyc('0, 0, 1, 4);
    check("r039_again", 32'(int_completion), 0);
    cyc('0, 0, 1, 0);
    cyc('0, 0, 1, 9);
    check("r039_id9", 32'(int_completion), 0);

    // reset lands on the claim edge
    pr[6] = 7;
    cyc(8'h40, 0, 0, 0);
    claim_req = 1'b1;
    #2 kplic_rstn = 1'b0;
    @(posedge kplic_clk);
    #1;
    check("r040_vld", 32'(claim_vld), 0);
    check_all_zero("r040_outs");
    m_pend = '0; m_svc = '0;
    @(negedge kplic_clk);
    claim_req = 1'b0;
    @(negedge kplic_clk);
    kplic_rstn = 1'b1;
    @(negedge kplic_clk);

    for (int it = 0; it < 600; it++) begin
      bit [N-1:0] rq;
      bit clm, cpl;
      int cid;
      if (it % 50 == 0) begin
        for (int i = 0; i < N; i++) pr[i] = int'($urandom_range(0, 7));
        thr = int'($urandom_range(0, 7));
      end
      rq = '0;
      for (int i = 0; i < N; i++) rq[i] = ($urandom_range(0, 7) == 0);
      clm = ($urandom_range(0, 2) == 0);
      cpl = ($urandom_range(0, 1) == 0);
      cid = int'($urandom_range(0, 15));
      if (m_svc != 0 && $urandom_range(0, 3) != 0) begin
        do cid = int'($urandom_range(1, N)); while (!m_svc[cid-1]);
      end
      cyc(rq, clm, cpl, cid);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
